correlator_readout_sequencer: RTL

Timing and readout controller for the correlator accumulator bank. Generates the sample strobe and the integration strobe. At each integration boundary it commands the bank to swap into its shadow copy, then walks all NUM_CORRELATORS shadow accumulators. Each value is serialized as a framed byte stream to the UART transmitter through a valid/ready handshake.

---
 rtl/correlator_readout_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/correlator_readout_sequencer.sv
// Sample/integration strobe generator and framed serial readout of the correlator bank.
// Optional trailing XOR checksum byte is enabled by defining CORR_READOUT_CHECKSUM_EN.
module correlator_readout_sequencer #(
  parameter int unsigned SAMPLE_DIV          = 50,
  parameter int unsigned INTEGRATION_SAMPLES = 100000,
  parameter int unsigned NUM_CORRELATORS     = 66,
  parameter int unsigned ADDR_W              = 7,
  parameter int unsigned ACC_W               = 32
) (
  input  logic              clki,
  input  logic              rsti_n,
  input  logic              enable,
  output logic              sample_clk_pulse,
  output logic              integration_clk_pulse,
  output logic              acc_swap,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [ACC_W-1:0]  rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned SdW    = $clog2(SAMPLE_DIV);
  localparam int unsigned IsW    = $clog2(INTEGRATION_SAMPLES + 1);
  localparam int unsigned NBytes = ACC_W / 8;
  localparam int unsigned BcW    = (NBytes > 1) ? $clog2(NBytes) : 1;

  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StSeq, StRd, StWait, StByte, StCsum
  } state_e;

  state_e             state_q, state_d;
  logic [SdW-1:0]     samp_q, samp_d;
  logic [IsW-1:0]     integ_q, integ_d;
  logic [7:0]         seq_q, seq_d;
  logic [7:0]         fseq_q, fseq_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BcW-1:0]     bcnt_q, bcnt_d;
  logic [ACC_W-1:0]   shreg_q, shreg_d;
  logic [7:0]         csum_q, csum_d;
  logic               overrun_q, overrun_d;
  logic               samp_pulse, int_pulse, tx_fire;

  // Timing generator: both counters are held at zero whenever enable is low.
  always_comb begin
    samp_pulse = enable && (samp_q == SdW'(SAMPLE_DIV - 1));
    int_pulse  = samp_pulse && (integ_q == IsW'(INTEGRATION_SAMPLES - 1));
    samp_d     = samp_q;
    integ_d    = integ_q;
    if (!enable) begin
      samp_d  = '0;
      integ_d = '0;
    end else begin
      samp_d = samp_pulse ? '0 : samp_q + SdW'(1);
      if (int_pulse) begin
        integ_d = '0;
      end else if (samp_pulse) begin
        integ_d = integ_q + IsW'(1);
      end
    end
  end

  assign sample_clk_pulse      = samp_pulse;
  assign integration_clk_pulse = int_pulse;
  assign acc_swap              = int_pulse;
  assign busy                  = (state_q != StIdle);
  assign overrun               = overrun_q;
  assign rd_addr               = addr_q;
  assign tx_fire               = tx_valid & tx_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    csum_d    = csum_q;
    fseq_d    = fseq_q;
    rd_en     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    // seq counts every integration, including dropped frames, so gaps are visible.
    seq_d     = seq_q + {7'd0, int_pulse};
    overrun_d = overrun_q | (int_pulse && (state_q != StIdle));

    case (state_q)
      StIdle: begin
        if (int_pulse) begin
          state_d = StHdr0;
          addr_d  = '0;
          csum_d  = 8'h00;
          fseq_d  = seq_q;
        end
      end
      StHdr0: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        if (tx_fire) state_d = StHdr1;
      end
      StHdr1: begin
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        if (tx_fire) state_d = StSeq;
      end
      StSeq: begin
        tx_valid = 1'b1;
        tx_data  = fseq_q;
        if (tx_fire) begin
          csum_d  = csum_q ^ fseq_q;
          state_d = StRd;
        end
      end
      StRd: begin
        rd_en   = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        shreg_d = rd_data;
        bcnt_d  = '0;
        state_d = StByte;
      end
      StByte: begin
        tx_valid = 1'b1;
        tx_data  = shreg_q[ACC_W-1 -: 8];
        if (tx_fire) begin
          csum_d  = csum_q ^ shreg_q[ACC_W-1 -: 8];
          shreg_d = shreg_q << 8;
          if (bcnt_q == BcW'(NBytes - 1)) begin
            if (addr_q == ADDR_W'(NUM_CORRELATORS - 1)) begin
`ifdef CORR_READOUT_CHECKSUM_EN
              state_d = StCsum;
`else
              state_d = StIdle;
`endif
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = StRd;
            end
          end else begin
            bcnt_d = bcnt_q + BcW'(1);
          end
        end
      end
`ifdef CORR_READOUT_CHECKSUM_EN
      StCsum: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_fire) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clki or negedge rsti_n) begin
    if (!rsti_n) begin
      state_q   <= StIdle;
      samp_q    <= '0;
      integ_q   <= '0;
      seq_q     <= 8'h00;
      fseq_q    <= 8'h00;
      addr_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      csum_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      integ_q   <= integ_d;
      seq_q     <= seq_d;
      fseq_q    <= fseq_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      csum_q    <= csum_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
